// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl: iterative AES-128/192/256 decryption sequencer.
// One inverse round per clock; InvShiftRows+InvSubBytes live outside.

module inv_MixColumns (
  input  logic [127:0] din,
  output logic [127:0] dout
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(
    input logic [7:0] a,
    input logic [3:0] k
  );
    logic [7:0] a2, a4, a8;
    a2 = xt(a);
    a4 = xt(a2);
    a8 = xt(a4);
    return (k[0] ? a  : 8'h00) ^
           (k[1] ? a2 : 8'h00) ^
           (k[2] ? a4 : 8'h00) ^
           (k[3] ? a8 : 8'h00);
  endfunction

  // per column: circulant {0e,0b,0d,09} over the four row bytes
  always_comb begin
    dout = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        dout[32*c+8*r +: 8] =
          gm(din[32*c+8*r +: 8], 4'he) ^
          gm(din[32*c+8*((r+1)%4) +: 8], 4'hb) ^
          gm(din[32*c+8*((r+2)%4) +: 8], 4'hd) ^
          gm(din[32*c+8*((r+3)%4) +: 8], 4'h9);
      end
    end
  end

endmodule

module aes_inv_round_ctrl #(
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  input  logic [1:0]        key_len,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [127:0]      rk_in,
  output logic [127:0]      isb_in,
  input  logic [127:0]      isb_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    ADDK,
    ROUND,
    FINAL,
    DONE
  } st_t;

  st_t          st, st_n;
  logic [127:0] state_q, state_n;
  logic [127:0] od_q, od_n;
  logic [127:0] imc_out;
  logic [3:0]   nr_q, nr_n;
  logic [3:0]   rnd_q, rnd_n;
  logic [3:0]   kidx;
  logic         ov_q, ov_n;
  logic         err_q, err_n;

  inv_MixColumns u_imc (
    .din  (isb_out ^ rk_in),
    .dout (imc_out)
  );

  // all sequencer and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      state_q <= '0;
      od_q    <= '0;
      nr_q    <= '0;
      rnd_q   <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st      <= st_n;
      state_q <= state_n;
      od_q    <= od_n;
      nr_q    <= nr_n;
      rnd_q   <= rnd_n;
      ov_q    <= ov_n;
      err_q   <= err_n;
    end
  end

  // next state, round sequencing, key index and AddRoundKey
  always_comb begin
    st_n    = st;
    state_n = state_q;
    od_n    = od_q;
    nr_n    = nr_q;
    rnd_n   = rnd_q;
    ov_n    = ov_q;
    err_n   = 1'b0;
    kidx    = '0;
    unique case (st)
      IDLE: begin
        if (in_valid) begin
          if (key_len != 2'b11) begin
            state_n = in_data;
            nr_n    = 4'd10 + {1'b0, key_len, 1'b0};
            st_n    = ADDK;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ADDK: begin
        kidx    = nr_q;
        state_n = state_q ^ rk_in;
        rnd_n   = nr_q - 4'd1;
        st_n    = ROUND;
      end
      ROUND: begin
        kidx    = rnd_q;
        state_n = imc_out;
        if (rnd_q == 4'd1) st_n = FINAL;
        else rnd_n = rnd_q - 4'd1;
      end
      FINAL: begin
        od_n = isb_out ^ rk_in;
        ov_n = 1'b1;
        st_n = DONE;
      end
      DONE: begin
        if (out_ready) begin
          ov_n = 1'b0;
          st_n = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  assign in_ready  = (st == IDLE);
  assign busy      = (st != IDLE);
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign err       = err_q;
  assign key_idx   = KIDX_W'(kidx);
  assign isb_in    = state_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// tb_aes_inv_round_ctrl: FIPS-197 vectors plus random blocks checked
// against a forward AES encryption model; also handshake/reset cases.

module tb_aes_inv_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [1:0]   key_len;
  logic [3:0]   key_idx;
  logic [127:0] rk_in;
  logic [127:0] isb_in;
  logic [127:0] isb_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [7:0]   key_b [32];
  logic [127:0] rk_tab[16];

  always #5 clk = ~clk;

  aes_inv_round_ctrl #(.KIDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key_len   (key_len),
    .key_idx   (key_idx),
    .rk_in     (rk_in),
    .isb_in    (isb_in),
    .isb_out   (isb_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .err       (err)
  );

  assign rk_in = rk_tab[key_idx];

  always_comb begin
    isb_out = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        isb_out[8*(r+4*c) +: 8] =
          isbox[isb_in[8*(r+4*((c+4-r)%4)) +: 8]];
  end

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] x, int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  function automatic logic [127:0] bswap(logic [127:0] x);
    logic [127:0] y;
    for (int j = 0; j < 16; j++) y[8*j +: 8] = x[127-8*j -: 8];
    return y;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
          rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic set_key(int nk);
    logic [7:0] w [60][4];
    logic [7:0] t [4];
    logic [7:0] tmp;
    logic [7:0] rc = 8'h01;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++)
      for (int b = 0; b < 4; b++) w[i][b] = key_b[4*i+b];
    for (int i = nk; i < 4*(nr+1); i++) begin
      for (int b = 0; b < 4; b++) t[b] = w[i-1][b];
      if (i % nk == 0) begin
        tmp = t[0];
        t[0] = sbox[t[1]];
        t[1] = sbox[t[2]];
        t[2] = sbox[t[3]];
        t[3] = sbox[tmp];
        t[0] = t[0] ^ rc;
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        for (int b = 0; b < 4; b++) t[b] = sbox[t[b]];
      end
      for (int b = 0; b < 4; b++) w[i][b] = w[i-nk][b] ^ t[b];
    end
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    for (int r = 0; r <= nr; r++)
      for (int j = 0; j < 16; j++)
        rk_tab[r][8*j +: 8] = w[4*r + j/4][j%4];
  endtask

  function automatic logic [127:0] aes_enc(logic [127:0] pt, int nr);
    logic [127:0] s, t;
    s = pt ^ rk_tab[0];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[8*(r+4*c) +: 8] = sbox[s[8*(r+4*((c+r)%4)) +: 8]];
      if (rd != nr) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[8*(r+4*c) +: 8] =
              gmul(t[8*(r+4*c) +: 8], 8'h02) ^
              gmul(t[8*((r+1)%4+4*c) +: 8], 8'h03) ^
              t[8*((r+2)%4+4*c) +: 8] ^
              t[8*((r+3)%4+4*c) +: 8];
      end else begin
        s = t;
      end
      s = s ^ rk_tab[rd];
    end
    return s;
  endfunction

  task automatic seq_key(int nbytes);
    for (int j = 0; j < 32; j++) key_b[j] = (j < nbytes) ? 8'(j) : 8'h00;
  endtask

  task automatic wait_ready(string tag);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, in_ready, 1);
  endtask

  task automatic accept(logic [127:0] ct, logic [1:0] kl);
    in_data  = ct;
    key_len  = kl;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    key_len  = 2'($urandom);
  endtask

  task automatic collect(string tag, int nr, logic [127:0] exp);
    int n = 0;
    bit kok = 1'b1;
    int ek;
    while (!out_valid && n < 40) begin
      ek = (n < nr) ? nr - n : 0;
      if (int'(key_idx) != ek || !busy) kok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, nr + 1);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_kseq"}, kok, 1);
  endtask

  task automatic handshake(string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_hs_ov"}, out_valid, 0);
    check({tag, "_hs_rdy"}, in_ready, 1);
  endtask

  task automatic run_c1(string tag);
    seq_key(16);
    set_key(4);
    wait_ready({tag, "_rdy"});
    accept(bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a), 2'b00);
    collect(tag, 10, bswap(128'h00112233445566778899aabbccddeeff));
    handshake(tag);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_ov"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rdy"}, in_ready, 1);
    check({tag, "_kidx"}, key_idx, 0);
  endtask

  initial begin
    logic [127:0] pt, ct, od;
    logic [1:0]   kl;
    bit           ok, ok2;
    int           nk;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    key_len   = 2'b00;
    out_ready = 1'b0;
    init_sbox();
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_rdy", in_ready, 1);
    check("rst_ov", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_kidx", key_idx, 0);
    check("rst_od", out_data, 0);
    rst = 1'b0;

    run_c1("c1");

    seq_key(24);
    set_key(6);
    wait_ready("c2_rdy");
    accept(bswap(128'hdda97ca4864cdfe06eaf70a0ec0d7191), 2'b01);
    collect("c2", 12, bswap(128'h00112233445566778899aabbccddeeff));
    handshake("c2");

    seq_key(32);
    set_key(8);
    wait_ready("c3_rdy");
    accept(bswap(128'h8ea2b7ca516745bfeafc49904b496089), 2'b10);
    collect("c3", 14, bswap(128'h00112233445566778899aabbccddeeff));
    handshake("c3");

    // backpressure with a second block waiting
    seq_key(16);
    set_key(4);
    wait_ready("bp_rdy");
    accept(bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a), 2'b00);
    collect("bp1", 10, bswap(128'h00112233445566778899aabbccddeeff));
    pt = {$urandom, $urandom, $urandom, $urandom};
    ct = aes_enc(pt, 10);
    in_data  = ct;
    key_len  = 2'b00;
    in_valid = 1'b1;
    od  = out_data;
    ok  = 1'b1;
    ok2 = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_data !== od || !out_valid) ok = 1'b0;
      if (in_ready) ok2 = 1'b0;
    end
    check("bp_stable", ok, 1);
    check("bp_noready", ok2, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_hs_rdy", in_ready, 1);
    check("bp_hs_ov", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_acc", busy, 1);
    collect("bp2", 10, pt);
    handshake("bp2");

    // illegal key length
    wait_ready("ill_rdy");
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    key_len  = 2'b11;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ill_err", err, 1);
    check("ill_busy", busy, 0);
    ok = 1'b1;
    @(posedge clk); #1;
    check("ill_err_off", err, 0);
    repeat (15) begin
      if (busy || out_valid || err) ok = 1'b0;
      @(posedge clk); #1;
    end
    check("ill_quiet", ok, 1);
    run_c1("ill_c1");

    // reset during ROUND, round 5
    wait_ready("rr_rdy");
    accept(bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a), 2'b00);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("rr_at5", key_idx, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset("rr");
    ok = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid || busy) ok = 1'b0;
    end
    check("rr_quiet", ok, 1);
    run_c1("rr_c1");

    // reset during DONE
    wait_ready("rd_rdy");
    accept(bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a), 2'b00);
    collect("rd", 10, bswap(128'h00112233445566778899aabbccddeeff));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset("rd");
    run_c1("rd_c1");

    // random keys, lengths and plaintexts vs forward-AES model
    for (int it = 0; it < 12; it++) begin
      kl = 2'($urandom_range(0, 2));
      nk = 4 + 2 * int'(kl);
      for (int j = 0; j < 32; j++) key_b[j] = 8'($urandom);
      set_key(nk);
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = aes_enc(pt, nk + 6);
      wait_ready("rnd_rdy");
      accept(ct, kl);
      collect("rnd", nk + 6, pt);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      handshake("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_inv_round_ctrl.md
Name: aes_inv_round_ctrl

Overview:
- Iterative AES-128/192/256 decryption sequencer that executes one inverse round per clock.
- Owns the 128-bit state register, the AddRoundKey XOR, the round counter and a valid/ready handshake on both sides.
- Instantiates inv_MixColumns for the middle rounds.
- Delegates InvShiftRows+InvSubBytes to an external combinational datapath (isb_* ports) and fetches round keys from the key-schedule storage by index (key_idx/rk_in).

Parameters:
- KIDX_W, 4, width of the round-key index (max index 14).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ciphertext + key_len offered
- in_ready  out  1  block can accept (IDLE only)
- in_data  in  128  ciphertext, byte j at [8*j+:8], column-major (byte i+4*c = row i, col c)
- key_len  in  2  00=AES-128 (Nr=10), 01=AES-192 (Nr=12), 10=AES-256 (Nr=14), 11=illegal
- key_idx  out  KIDX_W  round-key index requested this cycle
- rk_in  in  128  round key w[key_idx], combinational same-cycle return, same byte order
- isb_in  out  128  state presented to external InvShiftRows+InvSubBytes
- isb_out  in  128  combinational result of isb_in
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts plaintext
- out_data  out  128  plaintext, same byte order
- busy  out  1  high in any state except IDLE
- err  out  1  one-cycle pulse on illegal key_len

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, err=0, key_idx=0, state register and out_data=0, round counter=0.
- FSM states: IDLE, ADDK, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1, key_idx=0.
  - On in_valid with key_len!=11: latch in_data into state, latch Nr, go to ADDK.
  - On in_valid with key_len==11: pulse err for one cycle, stay IDLE, latch nothing.
- ADDK:
  - key_idx=Nr; state <= state ^ rk_in; round <= Nr-1; go to ROUND.
- ROUND:
  - key_idx=round; isb_in=state.
  - state <= InvMixColumns(isb_out ^ rk_in), using the instantiated inv_MixColumns.
  - If round==1, go to FINAL; otherwise round <= round-1.
- FINAL:
  - key_idx=0; isb_in=state.
  - out_data <= isb_out ^ rk_in; out_valid <= 1; go to DONE.
- DONE:
  - out_valid=1, out_data held stable.
  - On out_ready: out_valid <= 0, go to IDLE, in_ready=1 on the next cycle.
- Outside ROUND and FINAL, isb_in is driven with the state register. The value is don't-care but must be glitch-free registered.
- Latency: out_valid rises exactly Nr+1 cycles after the accepting edge (11/13/15). No pipelining; at most one block in flight.
- Throughput with out_ready tied high: one block per Nr+3 cycles, since in_ready is low from the accepting edge until the cycle after DONE.
- in_valid while busy is ignored: in_ready=0 and no state change.
- out_ready while not in DONE is ignored.
- key_len is sampled only at acceptance. Later changes have no effect on the block in flight.
- Reset mid-operation (any state, including DONE with out_valid high):
  - Next cycle matches the reset values.
  - The in-flight block is discarded, with no out_valid pulse.
- Round counter is 4 bits and never wraps below 1 in ROUND.
- All arithmetic is GF(2^8) with reduction polynomial 0x11b, inside inv_MixColumns.

Test Plan:
- AES-128, FIPS-197 C.1: ciphertext bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a (byte0 at [7:0]); bench key model expands 000102..0f. -> out_valid 11 cycles after accept; out_data bytes 00 11 22 ... ff; key_idx sequence 10,9,...,1,0.
- AES-192, C.2: ct dd a9 7c a4 86 4c df e0 6e af 70 a0 ec 0d 71 91, key 000102..17. -> plaintext 00112233..ff at 13 cycles; key_idx starts at 12.
- AES-256, C.3: ct 8e a2 b7 ca 51 67 45 bf ea fc 49 90 4b 49 60 89, key 000102..1f. -> plaintext 00112233..ff at 15 cycles.
- Backpressure: out_ready=0 for 20 cycles after out_valid, in_valid held high with a second block. -> out_data stable, in_ready=0 throughout; the second block is accepted the cycle after the out_ready handshake and decrypts correctly.
- Illegal key_len=11 with in_valid. -> err high exactly one cycle, busy stays 0, no out_valid. Then a legal AES-128 request completes normally.
- Assert rst during ROUND (round 5), and separately during DONE. -> next cycle: out_valid=0, busy=0, in_ready=1, key_idx=0. A subsequent C.1 vector produces the correct plaintext.
